// File: rtl/pps_pkg.sv
// Shared constants and helpers for the PPS tick generator.
package pps_pkg;

  // pps_in rise to pps_valid / align tick: two synchroniser flops plus one edge-detect flop.
  localparam int unsigned PPS_EDGE_LAT = 3;

  // Rounded 2^acc_w / clk_hz, i.e. the accumulator increment for a 1 Hz tick.
  function automatic longint unsigned pps_default_inc(input longint unsigned clk_hz,
                                                      input int unsigned acc_w);
    return ((64'd1 << (acc_w + 1)) + clk_hz) / (64'd2 * clk_hz);
  endfunction

  // Channel select width, never narrower than one bit.
  function automatic int unsigned pps_ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/pps_tick_gen_if.sv
// Configuration, PPS input and tick/measurement outputs of pps_tick_gen.
interface pps_tick_gen_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned LEN_W  = 24
);
  localparam int unsigned CH_W = pps_pkg::pps_ch_w(NUM_CH);

  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic [LEN_W-1:0]  cfg_len;
  logic [NUM_CH-1:0] ch_en;
  logic              align_en;
  logic              pps_in;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pulse;
  logic [31:0]       pps_period;
  logic              pps_valid;
  logic              pps_ok;

  modport master (
    output cfg_we, cfg_ch, cfg_inc, cfg_len, ch_en, align_en, pps_in,
    input  tick, pulse, pps_period, pps_valid, pps_ok
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_inc, cfg_len, ch_en, align_en, pps_in,
    output tick, pulse, pps_period, pps_valid, pps_ok
  );

endinterface

// File: rtl/pps_channel.sv
// One fractional-divider channel: phase accumulator, wrap tick and retriggerable pulse stretcher.
module pps_channel #(
  parameter int unsigned      ACC_W   = 32,
  parameter int unsigned      LEN_W   = 24,
  parameter logic [ACC_W-1:0] INC_RST = {ACC_W{1'b0}},
  parameter logic [LEN_W-1:0] LEN_RST = {LEN_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             align_i,
  input  logic             cfg_we_i,
  input  logic [ACC_W-1:0] cfg_inc_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  output logic             tick_o,
  output logic             pulse_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             pulse_q, pulse_d;
  logic [ACC_W:0]   sum_c;

  always_comb begin
    sum_c   = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d   = acc_q;
    tick_d  = 1'b0;
    inc_d   = inc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    // Align forces a wrap on enabled channels; disabled ones are only zeroed.
    if (align_i) begin
      acc_d  = {ACC_W{1'b0}};
      tick_d = en_i;
    end else if (en_i) begin
      acc_d  = sum_c[ACC_W-1:0];
      tick_d = sum_c[ACC_W];
    end

    if (cfg_we_i) begin
      inc_d = cfg_inc_i;
      len_d = cfg_len_i;
    end

    // cnt holds the remaining high cycles including the current one.
    if (tick_d) begin
      cnt_d = len_q;
    end else if (cnt_q != {LEN_W{1'b0}}) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
    pulse_d = (cnt_d != {LEN_W{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= {ACC_W{1'b0}};
      inc_q   <= INC_RST;
      len_q   <= LEN_RST;
      cnt_q   <= {LEN_W{1'b0}};
      tick_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      pulse_q <= pulse_d;
    end
  end

  assign tick_o  = tick_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/pps_tick_gen.sv
// Multi-channel tick/pulse generator with external PPS period monitor and phase alignment.
module pps_tick_gen
  import pps_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 60_000_000,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned LEN_W   = 24,
  parameter int unsigned TOL_CYC = 1000
) (
  input logic          clk,
  input logic          reset,
  pps_tick_gen_if.slave bus
);

  localparam int unsigned CH_W   = pps_ch_w(NUM_CH);
  localparam logic [31:0] PER_LO = 32'(CLK_HZ - TOL_CYC);
  localparam logic [31:0] PER_HI = 32'(CLK_HZ + TOL_CYC);

  logic [PPS_EDGE_LAT-1:0] sync_q, sync_d;
  logic [31:0]             cnt_q, cnt_d;
  logic [31:0]             period_q, period_d;
  logic                    seen_q, seen_d;
  logic                    valid_q, valid_d;
  logic                    ok_q, ok_d;
  logic                    pps_edge_c;
  logic                    align_c;
  logic [NUM_CH-1:0]       tick_w;
  logic [NUM_CH-1:0]       pulse_w;

  always_comb begin
    // sync_q[0..1] synchronise pps_in, sync_q[2] is the previous synchronised level.
    sync_d     = {sync_q[PPS_EDGE_LAT-2:0], bus.pps_in};
    pps_edge_c = sync_q[1] & ~sync_q[2];
    align_c    = pps_edge_c & bus.align_en;

    cnt_d    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    period_d = period_q;
    seen_d   = seen_q;
    valid_d  = 1'b0;
    ok_d     = ok_q;

    if (cnt_q == 32'hFFFF_FFFF) begin
      ok_d = 1'b0;
    end

    // The first edge after reset only starts the measurement window.
    if (pps_edge_c) begin
      cnt_d  = 32'd0;
      seen_d = 1'b1;
      if (seen_q) begin
        period_d = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
        valid_d  = 1'b1;
        ok_d     = (period_d >= PER_LO) && (period_d <= PER_HI);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {PPS_EDGE_LAT{1'b0}};
      cnt_q    <= 32'd0;
      period_q <= 32'd0;
      seen_q   <= 1'b0;
      valid_q  <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      seen_q   <= seen_d;
      valid_q  <= valid_d;
      ok_q     <= ok_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [ACC_W-1:0] INC_RST =
      (i == 0) ? ACC_W'(pps_default_inc(64'(CLK_HZ), ACC_W)) : {ACC_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_RST =
      (i == 0) ? LEN_W'(CLK_HZ / 10) : {LEN_W{1'b0}};

    pps_channel #(
      .ACC_W  (ACC_W),
      .LEN_W  (LEN_W),
      .INC_RST(INC_RST),
      .LEN_RST(LEN_RST)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en_i     (bus.ch_en[i]),
      .align_i  (align_c),
      .cfg_we_i (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
      .cfg_inc_i(bus.cfg_inc),
      .cfg_len_i(bus.cfg_len),
      .tick_o   (tick_w[i]),
      .pulse_o  (pulse_w[i])
    );
  end

  assign bus.tick       = tick_w;
  assign bus.pulse      = pulse_w;
  assign bus.pps_period = period_q;
  assign bus.pps_valid  = valid_q;
  assign bus.pps_ok     = ok_q;

endmodule

// File: tb/tb_pps_tick_gen.sv
// Directed bench for pps_tick_gen at CLK_HZ=1000, ACC_W=16, TOL_CYC=2.
module tb_pps_tick_gen;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned ACC_W   = 16;
  localparam int unsigned LEN_W   = 24;
  localparam int unsigned TOL_CYC = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_mis;

  pps_tick_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  pps_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W),
    .LEN_W  (LEN_W),
    .TOL_CYC(TOL_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input int ch, input logic [ACC_W-1:0] inc, input logic [LEN_W-1:0] len);
    bus.cfg_ch  = 2'(ch);
    bus.cfg_inc = inc;
    bus.cfg_len = len;
    bus.cfg_we  = 1'b1;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  // Steps until tick[ch] is seen (bounded) and checks the number of cycles taken.
  task automatic wait_tick(input int ch, input int exp_n, input string tag);
    int n;
    n = 0;
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (bus.tick[ch] === 1'b1) begin
        n = k;
        break;
      end
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic pps_rise(input logic exp_v, input logic [31:0] exp_p, input logic exp_ok,
                          input string tag);
    bus.pps_in = 1'b1;
    step();
    step();
    check({tag, "_not_early"}, 32'(bus.pps_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(bus.pps_valid), 32'(exp_v));
    if (exp_v) begin
      check({tag, "_period"}, bus.pps_period, exp_p);
      check({tag, "_ok"}, 32'(bus.pps_ok), 32'(exp_ok));
    end
  endtask

  task automatic pps_hold(input int n);
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) begin
        bus.pps_in = 1'b0;
        check("valid_one_cycle", 32'(bus.pps_valid), 32'd0);
      end
    end
  endtask

  initial begin
    int p;
    logic e1, e2;
    n_cmp        = 0;
    n_mis        = 0;
    reset        = 1'b1;
    bus.cfg_we   = 1'b0;
    bus.cfg_ch   = '0;
    bus.cfg_inc  = '0;
    bus.cfg_len  = '0;
    bus.ch_en    = '0;
    bus.align_en = 1'b0;
    bus.pps_in   = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_pulse", 32'(bus.pulse), 32'd0);
    check("rst_period", bus.pps_period, 32'd0);
    check("rst_valid", 32'(bus.pps_valid), 32'd0);
    check("rst_ok", 32'(bus.pps_ok), 32'd0);

    // Default ch0: inc=66 wraps after ceil(65536/66)=993 cycles, pulse 100 cycles.
    bus.ch_en = 4'b0001;
    wait_tick(0, 993, "default_first_tick");
    check("default_pulse_rise", 32'(bus.pulse[0]), 32'd1);
    p = 1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1) check("tick_one_cycle", 32'(bus.tick[0]), 32'd0);
      if (bus.pulse[0] !== 1'b1) break;
      p++;
    end
    check("default_pulse_len", 32'(p), 32'd100);
    bus.ch_en = 4'b0000;

    // 3/8 rate on ch1: ticks where floor(3n/8) steps.
    cfg_write(1, 16'd24576, 24'd1);
    bus.ch_en = 4'b0010;
    for (int n = 1; n <= 24; n++) begin
      step();
      e1 = ((3 * n) / 8) != ((3 * (n - 1)) / 8);
      check("frac_tick", 32'(bus.tick), 32'({2'b00, e1, 1'b0}));
      check("frac_pulse1", 32'(bus.pulse[1]), 32'(e1));
    end
    bus.ch_en = 4'b0000;

    // Half rate on ch2 with len=5: retrigger keeps pulse high.
    cfg_write(2, 16'd32768, 24'd5);
    bus.ch_en = 4'b0100;
    for (int n = 1; n <= 20; n++) begin
      step();
      check("retrig_tick", 32'(bus.tick[2]), 32'((n % 2) == 0));
      check("retrig_pulse", 32'(bus.pulse[2]), 32'(n >= 2));
    end
    cfg_write(2, 16'd32768, 24'd0);
    check("len_write_running", 32'(bus.pulse[2]), 32'd1);
    step();
    check("len0_retrig_tick", 32'(bus.tick[2]), 32'd1);
    check("len0_retrig_pulse", 32'(bus.pulse[2]), 32'd0);
    for (int n = 1; n <= 10; n++) begin
      step();
      check("len0_tick", 32'(bus.tick[2]), 32'((n % 2) == 0));
      check("len0_pulse", 32'(bus.pulse[2]), 32'd0);
    end
    bus.ch_en = 4'b0000;

    // PPS period measurement and tolerance boundaries.
    pps_rise(1'b0, 32'd0, 1'b0, "first_edge");
    pps_hold(997);
    pps_rise(1'b1, 32'd1000, 1'b1, "p1000");
    pps_hold(1002);
    pps_rise(1'b1, 32'd1005, 1'b0, "p1005");
    pps_hold(999);
    pps_rise(1'b1, 32'd1002, 1'b1, "p1002");
    pps_hold(994);
    pps_rise(1'b1, 32'd997, 1'b0, "p997");
    pps_hold(5);

    // Align: ch1/ch2 enabled mid-phase, ch0 disabled mid-phase.
    bus.align_en = 1'b1;
    bus.ch_en    = 4'b0110;
    for (int k = 0; k < 4; k++) step();
    bus.pps_in = 1'b1;
    step();
    step();
    step();
    check("align_tick", 32'(bus.tick), 32'b0110);
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 1) bus.pps_in = 1'b0;
      e1 = ((3 * n) / 8) != ((3 * (n - 1)) / 8);
      e2 = (n % 2) == 0;
      check("post_align_tick", 32'(bus.tick), 32'({1'b0, e2, e1, 1'b0}));
    end
    bus.align_en = 1'b0;
    bus.ch_en    = 4'b0001;
    wait_tick(0, 993, "align_cleared_acc0");

    // Reset during an active pulse with a PPS edge still in the synchroniser.
    for (int k = 0; k < 10; k++) step();
    check("pre_reset_pulse", 32'(bus.pulse[0]), 32'd1);
    bus.pps_in = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_tick", 32'(bus.tick), 32'd0);
    check("midrst_pulse", 32'(bus.pulse), 32'd0);
    check("midrst_period", bus.pps_period, 32'd0);
    check("midrst_valid", 32'(bus.pps_valid), 32'd0);
    check("midrst_ok", 32'(bus.pps_ok), 32'd0);
    pps_rise(1'b0, 32'd0, 1'b0, "post_reset_first");
    pps_hold(997);
    pps_rise(1'b1, 32'd1000, 1'b1, "post_reset_p1000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
